// File: rtl/adc_spi_master_if.sv
// Bundle of the ADC SPI pins and the sample-side control/result signals.
interface adc_spi_master_if;
  logic       enable;
  logic       start;
  logic       channel;
  logic       adc_miso;
  logic       adc_mosi;
  logic       adc_sck;
  logic       adc_cs_n;
  logic [9:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       overrun;

  modport master (
    input  enable, start, channel, adc_miso,
    output adc_mosi, adc_sck, adc_cs_n, sample, sample_valid, busy, overrun
  );

  modport slave (
    output enable, start, channel, adc_miso,
    input  adc_mosi, adc_sck, adc_cs_n, sample, sample_valid, busy, overrun
  );
endinterface

// File: rtl/adc_spi_master.sv
// Mode-0 SPI master that periodically polls an MCP3002-style 10-bit ADC
// and presents each conversion as a sample with a one-cycle valid strobe.
module adc_spi_master #(
  parameter int CLK_DIV       = 20,
  parameter int SAMPLE_PERIOD = 40000
) (
  input  logic             clk,
  input  logic             reset,
  adc_spi_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [4:0]         half_q, half_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        tx_q, tx_d;
  logic [9:0]         rx_q, rx_d;
  logic [9:0]         sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               sck_q, sck_d;

  logic               tick, trigger, div_last;
  logic               cs_n_o, busy_o, mosi_o;

  assign tick     = bus.enable && (timer_q == TMR_LAST);
  assign trigger  = tick || bus.start;
  assign div_last = (div_q == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: each timed state ends on the last clk of a half-period
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (trigger) state_d = CS_SETUP;
      CS_SETUP: if (div_last) state_d = SHIFT;
      SHIFT:    if (div_last && (half_q == 5'd31)) state_d = CS_HOLD;
      CS_HOLD:  if (div_last) state_d = GAP;
      GAP:      if (div_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; mosi only carries the command while selected
  always_comb begin
    cs_n_o = 1'b1;
    busy_o = (state_q != IDLE);
    mosi_o = 1'b0;
    if ((state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD)) cs_n_o = 1'b0;
    if ((state_q == CS_SETUP) || (state_q == SHIFT)) mosi_o = tx_q[15];
  end

  // Timer, half-period counter, shift registers and result capture
  always_comb begin
    div_d     = div_q;
    half_d    = half_q;
    timer_d   = timer_q;
    overrun_d = overrun_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    sck_d     = sck_q;

    if (!bus.enable) begin
      timer_d   = '0;
      overrun_d = 1'b0;
    end else begin
      timer_d = (timer_q == TMR_LAST) ? '0 : timer_q + TMR_W'(1);
      if (tick && (state_q != IDLE)) overrun_d = 1'b1;
    end

    if ((state_q == IDLE) || div_last) div_d = '0;
    else                               div_d = div_q + DIV_W'(1);

    if (state_q != SHIFT) half_d = '0;
    else if (div_last)    half_d = half_q + 5'd1;

    if ((state_q == IDLE) && trigger)
      tx_d = {1'b0, 1'b1, 1'b1, bus.channel, 1'b1, 11'b0};

    // Even half ends with sck rising (capture miso), odd half with sck falling (advance mosi)
    if ((state_q == SHIFT) && div_last) begin
      if (!half_q[0]) begin
        sck_d = 1'b1;
        rx_d  = {rx_q[8:0], bus.adc_miso};
      end else begin
        sck_d = 1'b0;
        tx_d  = {tx_q[14:0], 1'b0};
      end
    end

    if ((state_q == CS_HOLD) && div_last) begin
      valid_d  = 1'b1;
      sample_d = rx_q;
    end
  end

  // Datapath and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      half_q    <= '0;
      timer_q   <= '0;
      overrun_q <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      sck_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      half_q    <= half_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      sck_q     <= sck_d;
    end
  end

  assign bus.adc_cs_n     = cs_n_o;
  assign bus.adc_sck      = sck_q;
  assign bus.adc_mosi     = mosi_o;
  assign bus.busy         = busy_o;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: directed frame vectors, periodic polling,
// overrun and mid-frame reset, against a behavioural MCP3002 model.
module tb_adc_spi_master;
  localparam int CD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_spi_master_if bus0();
  adc_spi_master_if bus1();

  adc_spi_master #(.CLK_DIV(CD), .SAMPLE_PERIOD(1000)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master)
  );
  adc_spi_master #(.CLK_DIV(CD), .SAMPLE_PERIOD(100)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master)
  );

  // ADC model state and monitors for dut0
  logic [9:0]  adc_val = '0;
  logic [15:0] cmd = '0;
  logic [9:0]  prev_sample = '0;
  logic        sck_prev = 1'b0;
  logic        cs_prev = 1'b1;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          valid_cnt = 0;
  int          last_valid_cyc = 0;
  int          spur = 0;

  function automatic logic miso_bit(input int e);
    if (e >= 7 && e <= 16) return adc_val[4'(16 - e)];
    return 1'b0;
  endfunction

  // MCP3002 behaviour: shifts data out after each falling sck, null bit on edge 6
  always @(negedge clk) begin
    if (bus0.adc_cs_n) bus0.adc_miso = 1'b0;
    else begin
      if (cs_prev) begin
        rise_cnt = 0;
        fall_cnt = 0;
      end
      if (bus0.adc_sck && !sck_prev) begin
        rise_cnt++;
        cmd = {cmd[14:0], bus0.adc_mosi};
      end
      if (!bus0.adc_sck && sck_prev) begin
        fall_cnt++;
        bus0.adc_miso = miso_bit(fall_cnt + 1);
      end
    end
    cs_prev  = bus0.adc_cs_n;
    sck_prev = bus0.adc_sck;
    if (bus0.sample_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end else if (!reset && (bus0.sample !== prev_sample)) spur++;
    prev_sample = bus0.sample;
  end

  typedef struct {
    logic        ch;
    logic [9:0]  adc;
    logic [15:0] cmd;
    logic [9:0]  smp;
  } vec_t;

  vec_t vecs[4];

  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit got);
    int n;
    n   = valid_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick_n();
      if (valid_cnt != n) got = 1'b1;
    end
  endtask

  initial begin
    bit got;
    int c0;
    int nv;
    int v1;

    vecs[0] = '{1'b0, 10'h2A5, 16'h6800, 10'h2A5};
    vecs[1] = '{1'b1, 10'h3FF, 16'h7800, 10'h3FF};
    vecs[2] = '{1'b1, 10'h000, 16'h7800, 10'h000};
    vecs[3] = '{1'b0, 10'h155, 16'h6800, 10'h155};

    bus0.enable = 1'b0; bus0.start = 1'b0; bus0.channel = 1'b0;
    bus1.enable = 1'b0; bus1.start = 1'b0; bus1.channel = 1'b0;
    bus1.adc_miso = 1'b0;

    // Reset held two cycles
    tick_n(); tick_n();
    check("rst_cs_n",    bus0.adc_cs_n, 1);
    check("rst_sck",     bus0.adc_sck, 0);
    check("rst_mosi",    bus0.adc_mosi, 0);
    check("rst_sample",  bus0.sample, 0);
    check("rst_valid",   bus0.sample_valid, 0);
    check("rst_busy",    bus0.busy, 0);
    check("rst_overrun", bus0.overrun, 0);
    check("rst1_busy",   bus1.busy, 0);
    check("rst1_cs_n",   bus1.adc_cs_n, 1);
    reset = 1'b0;
    repeat (5) tick_n();
    check("idle_cs_n", bus0.adc_cs_n, 1);
    check("idle_sck",  bus0.adc_sck, 0);
    check("idle_busy", bus0.busy, 0);

    // Directed single conversions, with a channel change and an ignored start mid-frame
    for (int i = 0; i < 4; i++) begin
      adc_val      = vecs[i].adc;
      bus0.channel = vecs[i].ch;
      nv           = valid_cnt;
      bus0.start   = 1'b1;
      c0           = cyc;
      tick_n();
      bus0.start   = 1'b0;
      bus0.channel = ~vecs[i].ch;
      check("busy_after_start", bus0.busy, 1);
      check("cs_low_after_start", bus0.adc_cs_n, 0);
      repeat (48) tick_n();
      bus0.start = 1'b1;
      tick_n();
      bus0.start = 1'b0;
      wait_valid(150, got);
      check("valid_seen", got, 1);
      check("latency", last_valid_cyc - c0, 137);
      check("sample", bus0.sample, vecs[i].smp);
      check("mosi_cmd", cmd, vecs[i].cmd);
      check("sck_pulses", rise_cnt, 16);
      tick_n();
      check("valid_one_cycle", bus0.sample_valid, 0);
      repeat (40) tick_n();
      check("valid_count", valid_cnt - nv, 1);
      check("sample_held", bus0.sample, vecs[i].smp);
      check("idle_again_busy", bus0.busy, 0);
      check("idle_again_cs_n", bus0.adc_cs_n, 1);
    end

    // Periodic polling every 1000 cycles, then enable dropped mid-frame
    adc_val      = 10'h1C3;
    bus0.channel = 1'b0;
    bus0.enable  = 1'b1;
    wait_valid(1300, got);
    check("poll_valid1", got, 1);
    v1 = last_valid_cyc;
    wait_valid(1100, got);
    check("poll_valid2", got, 1);
    check("poll_period1", last_valid_cyc - v1, 1000);
    v1 = last_valid_cyc;
    wait_valid(1100, got);
    check("poll_valid3", got, 1);
    check("poll_period2", last_valid_cyc - v1, 1000);
    check("poll_sample", bus0.sample, 10'h1C3);
    check("poll_overrun", bus0.overrun, 0);
    repeat (10) tick_n();
    got = 1'b0;
    for (int i = 0; i < 1100 && !got; i++) begin
      tick_n();
      if (bus0.busy) got = 1'b1;
    end
    check("poll_busy_seen", got, 1);
    bus0.enable = 1'b0;
    nv = valid_cnt;
    wait_valid(200, got);
    check("disable_midframe_valid", got, 1);
    repeat (1200) tick_n();
    check("disable_no_more_valid", valid_cnt - nv, 1);
    check("disable_overrun", bus0.overrun, 0);

    // Overrun on dut1: period shorter than a frame
    bus1.enable = 1'b1;
    repeat (150) tick_n();
    check("ovr_busy_first", bus1.busy, 1);
    check("ovr_not_yet", bus1.overrun, 0);
    repeat (100) tick_n();
    check("ovr_set", bus1.overrun, 1);
    repeat (150) tick_n();
    check("ovr_sticky", bus1.overrun, 1);
    bus1.enable = 1'b0;
    tick_n();
    check("ovr_cleared", bus1.overrun, 0);
    repeat (200) tick_n();

    // Reset at the 10th sck rising edge, then a fresh conversion
    adc_val      = 10'h0F0;
    bus0.channel = 1'b0;
    bus0.start   = 1'b1;
    tick_n();
    bus0.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rise_cnt == 10 && bus0.adc_sck) got = 1'b1;
      else tick_n();
    end
    check("rise10_seen", got, 1);
    reset = 1'b1;
    tick_n();
    check("abort_cs_n",   bus0.adc_cs_n, 1);
    check("abort_sck",    bus0.adc_sck, 0);
    check("abort_busy",   bus0.busy, 0);
    check("abort_valid",  bus0.sample_valid, 0);
    check("abort_sample", bus0.sample, 0);
    reset = 1'b0;
    nv = valid_cnt;
    repeat (150) tick_n();
    check("abort_no_valid", valid_cnt - nv, 0);
    check("abort_sample_kept", bus0.sample, 0);
    bus0.channel = 1'b1;
    bus0.start   = 1'b1;
    c0           = cyc;
    tick_n();
    bus0.start = 1'b0;
    wait_valid(200, got);
    check("fresh_valid", got, 1);
    check("fresh_latency", last_valid_cyc - c0, 137);
    check("fresh_sample", bus0.sample, 10'h0F0);
    check("fresh_cmd", cmd, 16'h7800);

    check("no_spurious_sample_change", spur, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
